// File: rtl/fp8_log_unpack.sv
// fp8_log_unpack: classifies E4M3 operands for the log2 datapath behind a registered 2-entry skid buffer.
// Optional FP8_LOG_UNPACK_STATS_EN adds saturating nan/zero/subnormal counters.
module fp8_log_unpack #(
  parameter bit ZERO_IS_NAN = 1'b0,
  parameter bit NEG_IS_NAN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] exp_val,
  output logic       is_subnormal,
  output logic [2:0] mant_frac,
  output logic       is_zero,
  output logic       is_nan,
  output logic       is_one,
  output logic       sign_in
`ifdef FP8_LOG_UNPACK_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] nan_cnt,
  output logic [15:0] zero_cnt,
  output logic [15:0] subn_cnt
`endif
);
  logic [3:0]  e;
  logic [2:0]  m;
  logic        zero_in, subn_in, nan_in, acc, drain;
  logic [2:0]  frac;
  logic [11:0] rec, main_q, skid_q;
  assign e       = in_data[6:3];
  assign m       = in_data[2:0];
  assign zero_in = e == 4'd0 && m == 3'd0;
  assign subn_in = e == 4'd0 && m != 3'd0;
  assign nan_in  = (e == 4'hf && m == 3'h7) || (NEG_IS_NAN && in_data[7] && !zero_in) || (ZERO_IS_NAN && zero_in);
  // subnormal fraction: bits below the leading one, left-aligned
  assign frac    = !subn_in ? m : m[2] ? {m[1:0], 1'b0} : m[1] ? {m[0], 2'b00} : 3'b000;
  assign rec     = {e == 4'd0 ? {1'b0, m} : e, subn_in, frac, zero_in && !nan_in, nan_in,
                    in_data[6:0] == 7'h38 && !nan_in, in_data[7]};
  assign acc     = in_valid && in_ready;
  assign drain   = out_valid && out_ready;
  assign {exp_val, is_subnormal, mant_frac, is_zero, is_nan, is_one, sign_in} = main_q;
  // in_ready is kept as its own flop: it is high exactly when the skid register is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (drain) begin
      if (!in_ready) main_q <= skid_q;
      else if (acc) main_q <= rec;
      out_valid <= !in_ready || acc;
      in_ready  <= 1'b1;
    end else if (!out_valid) begin
      if (acc) main_q <= rec;
      out_valid <= acc;
    end else if (acc) begin
      skid_q   <= rec;
      in_ready <= 1'b0;
    end
  end
`ifdef FP8_LOG_UNPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt  <= '0;
      zero_cnt <= '0;
      subn_cnt <= '0;
    end else if (stats_clr) begin
      nan_cnt  <= '0;
      zero_cnt <= '0;
      subn_cnt <= '0;
    end else if (acc) begin
      nan_cnt  <= nan_cnt + 16'(rec[2] && ~&nan_cnt);
      zero_cnt <= zero_cnt + 16'(rec[3] && ~&zero_cnt);
      subn_cnt <= subn_cnt + 16'(rec[7] && ~&subn_cnt);
    end
  end
`endif
endmodule
